noc_cpu_endpoint: RTL and testbench

- Top-side (server-side) endpoint for one CPU, at the far end of the per-CPU cpu_to_noc / noc_to_cpu streams.
- Buffers CPU-originated flits and injects them into the NoC with routing fields decoded from the header.
- Accepts NoC flits addressed to this CPU, rewrites the header with the sender index, and buffers them for delivery back to the CPU.
- One instance per CPU index.

---
 rtl/noc_cpu_endpoint.sv | 155 +++++++++++++++
 tb/tb_noc_cpu_endpoint.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/noc_cpu_endpoint.sv
// ---------------------------------------------------------------------------
// noc_cpu_endpoint
//   Server-side endpoint for one CPU. CPU flits are buffered in an egress
//   FIFO and injected into the NoC with dst decoded from the flit header and
//   src set to this CPU's index. NoC flits addressed to this CPU have their
//   header (destination field) replaced by the sender index and are buffered
//   in an ingress FIFO toward the CPU; misaddressed flits are accepted and
//   dropped. Three saturating event counters are exported.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_index                own index (low IDX_WIDTH bits used)
//   cpu_to_noc_vld/rdy/...   CPU -> endpoint flit stream
//   noc_out_vld/rdy/data/dst/src  endpoint -> NoC injection
//   noc_in_vld/rdy/data/src/dst   NoC -> endpoint delivery
//   noc_to_cpu_vld/rdy/...   endpoint -> CPU flit stream
//   tx_count, rx_count, misroute_count  saturating event counters
// ---------------------------------------------------------------------------
module noc_cpu_endpoint #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cpu_index,
  input  logic                  cpu_to_noc_vld,
  output logic                  cpu_to_noc_rdy,
  input  logic [DATA_WIDTH-1:0] cpu_to_noc,
  output logic                  noc_out_vld,
  input  logic                  noc_out_rdy,
  output logic [DATA_WIDTH-1:0] noc_out_data,
  output logic [IDX_WIDTH-1:0]  noc_out_dst,
  output logic [IDX_WIDTH-1:0]  noc_out_src,
  input  logic                  noc_in_vld,
  output logic                  noc_in_rdy,
  input  logic [DATA_WIDTH-1:0] noc_in_data,
  input  logic [IDX_WIDTH-1:0]  noc_in_src,
  input  logic [IDX_WIDTH-1:0]  noc_in_dst,
  output logic                  noc_to_cpu_vld,
  input  logic                  noc_to_cpu_rdy,
  output logic [DATA_WIDTH-1:0] noc_to_cpu,
  output logic [31:0]           tx_count,
  output logic [31:0]           rx_count,
  output logic [31:0]           misroute_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Egress FIFO state
  logic [DATA_WIDTH-1:0] r_eg_mem [DEPTH];
  logic [PW-1:0]         r_eg_wr, r_eg_rd;
  logic [CW-1:0]         r_eg_cnt;

  // Ingress FIFO state
  logic [DATA_WIDTH-1:0] r_in_mem [DEPTH];
  logic [PW-1:0]         r_in_wr, r_in_rd;
  logic [CW-1:0]         r_in_cnt;

  logic [31:0] r_tx_cnt, r_rx_cnt, r_mis_cnt;

  logic w_eg_full, w_eg_empty, w_in_full, w_in_empty;
  logic w_eg_push, w_eg_pop, w_in_acc, w_in_match, w_in_push, w_in_pop;
  logic [IDX_WIDTH-1:0] w_own_idx;
  logic w_unused;

  assign w_own_idx  = cpu_index[IDX_WIDTH-1:0];
  // Upper index bits and the replaced header bits of delivered flits are
  // intentionally ignored.
  assign w_unused   = ^{cpu_index[31:IDX_WIDTH], noc_in_data[DATA_WIDTH-1 -: IDX_WIDTH]};

  assign w_eg_full  = (r_eg_cnt == CW'(DEPTH));
  assign w_eg_empty = (r_eg_cnt == '0);
  assign w_in_full  = (r_in_cnt == CW'(DEPTH));
  assign w_in_empty = (r_in_cnt == '0);

  // rdy is gated by rst directly so it is low for the whole reset pulse.
  assign cpu_to_noc_rdy = !w_eg_full && !rst;
  assign noc_in_rdy     = !w_in_full && !rst;

  assign noc_out_vld    = !w_eg_empty;
  assign noc_out_data   = r_eg_mem[r_eg_rd];
  assign noc_out_dst    = r_eg_mem[r_eg_rd][DATA_WIDTH-1 -: IDX_WIDTH];
  assign noc_out_src    = w_own_idx;

  assign noc_to_cpu_vld = !w_in_empty;
  assign noc_to_cpu     = r_in_mem[r_in_rd];

  assign w_eg_push  = cpu_to_noc_vld && cpu_to_noc_rdy;
  assign w_eg_pop   = noc_out_vld && noc_out_rdy;
  assign w_in_acc   = noc_in_vld && noc_in_rdy;
  assign w_in_match = (noc_in_dst == w_own_idx);
  assign w_in_push  = w_in_acc && w_in_match;
  assign w_in_pop   = noc_to_cpu_vld && noc_to_cpu_rdy;

  assign tx_count       = r_tx_cnt;
  assign rx_count       = r_rx_cnt;
  assign misroute_count = r_mis_cnt;

  // FIFO storage is not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_eg_push) r_eg_mem[r_eg_wr] <= cpu_to_noc;
    if (w_in_push) r_in_mem[r_in_wr] <= {noc_in_src, noc_in_data[DATA_WIDTH-IDX_WIDTH-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_eg_wr  <= '0;
      r_eg_rd  <= '0;
      r_eg_cnt <= '0;
    end else begin
      if (w_eg_push) r_eg_wr <= r_eg_wr + PW'(1);
      if (w_eg_pop)  r_eg_rd <= r_eg_rd + PW'(1);
      case ({w_eg_push, w_eg_pop})
        2'b10:   r_eg_cnt <= r_eg_cnt + CW'(1);
        2'b01:   r_eg_cnt <= r_eg_cnt - CW'(1);
        default: r_eg_cnt <= r_eg_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_wr  <= '0;
      r_in_rd  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) r_in_wr <= r_in_wr + PW'(1);
      if (w_in_pop)  r_in_rd <= r_in_rd + PW'(1);
      case ({w_in_push, w_in_pop})
        2'b10:   r_in_cnt <= r_in_cnt + CW'(1);
        2'b01:   r_in_cnt <= r_in_cnt - CW'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_cnt  <= '0;
      r_rx_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_eg_pop)              r_tx_cnt  <= sat_inc(r_tx_cnt);
      if (w_in_pop)              r_rx_cnt  <= sat_inc(r_rx_cnt);
      if (w_in_acc && !w_in_match) r_mis_cnt <= sat_inc(r_mis_cnt);
    end
  end

endmodule

// File: tb/tb_noc_cpu_endpoint.sv
module tb_noc_cpu_endpoint;
  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int IW    = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [31:0]   cpu_index;
  logic          cpu_to_noc_vld, cpu_to_noc_rdy;
  logic [DW-1:0] cpu_to_noc;
  logic          noc_out_vld, noc_out_rdy;
  logic [DW-1:0] noc_out_data;
  logic [IW-1:0] noc_out_dst, noc_out_src;
  logic          noc_in_vld, noc_in_rdy;
  logic [DW-1:0] noc_in_data;
  logic [IW-1:0] noc_in_src, noc_in_dst;
  logic          noc_to_cpu_vld, noc_to_cpu_rdy;
  logic [DW-1:0] noc_to_cpu;
  logic [31:0]   tx_count, rx_count, misroute_count;

  noc_cpu_endpoint #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .IDX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .cpu_index(cpu_index),
    .cpu_to_noc_vld(cpu_to_noc_vld), .cpu_to_noc_rdy(cpu_to_noc_rdy), .cpu_to_noc(cpu_to_noc),
    .noc_out_vld(noc_out_vld), .noc_out_rdy(noc_out_rdy), .noc_out_data(noc_out_data),
    .noc_out_dst(noc_out_dst), .noc_out_src(noc_out_src),
    .noc_in_vld(noc_in_vld), .noc_in_rdy(noc_in_rdy), .noc_in_data(noc_in_data),
    .noc_in_src(noc_in_src), .noc_in_dst(noc_in_dst),
    .noc_to_cpu_vld(noc_to_cpu_vld), .noc_to_cpu_rdy(noc_to_cpu_rdy), .noc_to_cpu(noc_to_cpu),
    .tx_count(tx_count), .rx_count(rx_count), .misroute_count(misroute_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: two bounded queues plus event tallies.
  logic [DW-1:0] eg_q[$];
  logic [DW-1:0] in_q[$];
  logic [31:0]   m_tx, m_rx, m_mis;
  logic [IW-1:0] own;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    eg_q.delete();
    in_q.delete();
    m_tx = 0; m_rx = 0; m_mis = 0;
  endtask

  // One clock cycle: drive inputs after the edge, compare outputs mid-cycle
  // against the model, then advance the model to what the next edge does.
  task automatic cycle(input logic c_vld, input logic [DW-1:0] c_data, input logic o_rdy,
                       input logic i_vld, input logic [DW-1:0] i_data,
                       input logic [IW-1:0] i_src, input logic [IW-1:0] i_dst,
                       input logic t_rdy);
    logic [DW-1:0] head;
    logic [IW-1:0] hdst;
    bit e_rdy, i_rdy, acc;
    @(posedge clk); #1;
    cpu_to_noc_vld = c_vld; cpu_to_noc = c_data; noc_out_rdy = o_rdy;
    noc_in_vld = i_vld; noc_in_data = i_data; noc_in_src = i_src; noc_in_dst = i_dst;
    noc_to_cpu_rdy = t_rdy;
    #4;
    e_rdy = (eg_q.size() < DEPTH);
    i_rdy = (in_q.size() < DEPTH);
    check("cpu_to_noc_rdy", 64'(cpu_to_noc_rdy), 64'(e_rdy));
    check("noc_in_rdy", 64'(noc_in_rdy), 64'(i_rdy));
    check("noc_out_vld", 64'(noc_out_vld), 64'(eg_q.size() > 0));
    check("noc_to_cpu_vld", 64'(noc_to_cpu_vld), 64'(in_q.size() > 0));
    if (eg_q.size() > 0) begin
      head = eg_q[0];
      hdst = head[DW-1 -: IW];
      check("noc_out_data", noc_out_data, head);
      check("noc_out_dst", 64'(noc_out_dst), 64'(hdst));
      check("noc_out_src", 64'(noc_out_src), 64'(own));
    end
    if (in_q.size() > 0) check("noc_to_cpu", noc_to_cpu, in_q[0]);
    check("tx_count", 64'(tx_count), 64'(m_tx));
    check("rx_count", 64'(rx_count), 64'(m_rx));
    check("misroute_count", 64'(misroute_count), 64'(m_mis));
    // advance model
    if (eg_q.size() > 0 && o_rdy) begin void'(eg_q.pop_front()); m_tx++; end
    if (c_vld && e_rdy) eg_q.push_back(c_data);
    if (in_q.size() > 0 && t_rdy) begin void'(in_q.pop_front()); m_rx++; end
    acc = i_vld && i_rdy;
    if (acc && i_dst == own) in_q.push_back({i_src, i_data[DW-IW-1:0]});
    else if (acc) m_mis++;
  endtask

  task automatic idle(input logic o_rdy, input logic t_rdy);
    cycle(1'b0, '0, o_rdy, 1'b0, '0, '0, '0, t_rdy);
  endtask

  initial begin
    logic [DW-1:0] d;
    rst = 1'b1; cpu_index = 32'd3; own = 8'd3;
    cpu_to_noc_vld = 0; cpu_to_noc = '0; noc_out_rdy = 0;
    noc_in_vld = 0; noc_in_data = '0; noc_in_src = '0; noc_in_dst = '0; noc_to_cpu_rdy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_vld", 64'(noc_out_vld), 64'd0);
    check("rst_to_cpu_vld", 64'(noc_to_cpu_vld), 64'd0);
    check("rst_c2n_rdy", 64'(cpu_to_noc_rdy), 64'd0);
    check("rst_in_rdy", 64'(noc_in_rdy), 64'd0);
    check("rst_tx", 64'(tx_count), 64'd0);
    check("rst_mis", 64'(misroute_count), 64'd0);
    @(posedge clk); #1 rst = 1'b0; #1;
    check("post_rst_c2n_rdy", 64'(cpu_to_noc_rdy), 64'd1);
    check("post_rst_in_rdy", 64'(noc_in_rdy), 64'd1);

    // single egress flit
    cycle(1'b1, 64'h05AA_0000_0000_1234, 1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(1'b1, 1'b1);
    check("t2_vld", 64'(noc_out_vld), 64'd1);
    check("t2_dst", 64'(noc_out_dst), 64'h05);
    check("t2_src", 64'(noc_out_src), 64'h03);
    check("t2_data", noc_out_data, 64'h05AA_0000_0000_1234);
    idle(1'b1, 1'b1);
    check("t2_tx", 64'(tx_count), 64'd1);

    // fill egress, then release with concurrent pushes
    for (int i = 0; i < 4; i++) cycle(1'b1, 64'h1000 + 64'(i), 1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(1'b0, 1'b1);
    check("t3_full_rdy", 64'(cpu_to_noc_rdy), 64'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 64'h2000 + 64'(i), 1'b1, 1'b0, '0, '0, '0, 1'b1);
    repeat (6) idle(1'b1, 1'b1);
    check("t3_tx", 64'(tx_count), 64'(m_tx));

    // ingress to self
    cycle(1'b0, '0, 1'b1, 1'b1, 64'hFF00_0000_0000_00AB, 8'd7, 8'd3, 1'b0);
    idle(1'b1, 1'b0);
    check("t4_vld", 64'(noc_to_cpu_vld), 64'd1);
    check("t4_data", noc_to_cpu, 64'h0700_0000_0000_00AB);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    // misaddressed
    cycle(1'b0, '0, 1'b1, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'd7, 8'd4, 1'b1);
    idle(1'b1, 1'b1);
    check("t5_vld", 64'(noc_to_cpu_vld), 64'd0);
    check("t5_mis", 64'(misroute_count), 64'd1);

    // reset mid-burst with two flits per FIFO
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 64'h3000 + 64'(i), 1'b0, 1'b1, 64'h4000 + 64'(i), 8'd9, 8'd3, 1'b0);
    idle(1'b0, 1'b0);
    check("t6_pre_out_vld", 64'(noc_out_vld), 64'd1);
    check("t6_pre_to_cpu_vld", 64'(noc_to_cpu_vld), 64'd1);
    rst = 1'b1; #1;
    check("t6_out_vld", 64'(noc_out_vld), 64'd0);
    check("t6_to_cpu_vld", 64'(noc_to_cpu_vld), 64'd0);
    check("t6_c2n_rdy", 64'(cpu_to_noc_rdy), 64'd0);
    check("t6_in_rdy", 64'(noc_in_rdy), 64'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    cpu_to_noc_vld = 0; noc_in_vld = 0; #1;
    check("t6_tx", 64'(tx_count), 64'd0);
    check("t6_rx", 64'(rx_count), 64'd0);
    check("t6_mis", 64'(misroute_count), 64'd0);
    check("t6_out_empty", 64'(noc_out_vld), 64'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      d = {$urandom(), $urandom()};
      cycle(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), {$urandom(), $urandom()}, 8'($urandom()),
            ($urandom_range(0, 3) != 0) ? own : 8'($urandom()),
            1'($urandom_range(0, 2) != 0));
    end
    repeat (8) idle(1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
